// File: rtl/pulse_channel_sched_pkg.sv
// ============================================================================
// pulse_sched_pkg : shared types for the pulse channel scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_channel_sched_if.sv
// ============================================================================
// pulse_channel_sched_if : request/ack/status bundle of the pulse scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface pulse_channel_sched_if #(
  parameter int N_REQ = 4
) ();

  localparam int ID_W = pulse_sched_pkg::id_width(N_REQ);

  logic [N_REQ-1:0] req_pulse;
  logic             ack_level_sync;
  logic             ovf_clr;
  logic             sync_level_o;
  logic [ID_W-1:0]  sync_id_o;
  logic             busy;
  logic [N_REQ-1:0] pend_nz;
  logic [N_REQ-1:0] ovf_sticky;

  modport master (
    input  req_pulse, ack_level_sync, ovf_clr,
    output sync_level_o, sync_id_o, busy, pend_nz, ovf_sticky
  );

  modport slave (
    output req_pulse, ack_level_sync, ovf_clr,
    input  sync_level_o, sync_id_o, busy, pend_nz, ovf_sticky
  );

endinterface

`default_nettype wire

// File: rtl/pulse_channel_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin pick among pending requesters, pointer advances on update
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic [N_REQ-1:0]           req,
  input  wire logic                       update,
  output logic      [N_REQ-1:0]           grant,
  output logic      [id_width(N_REQ)-1:0] idx,
  output logic                            valid
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] ptr;
  int              pos;

  // First pending requester at or after ptr, wrapping at N_REQ-1.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

  assign grant = valid ? (N_REQ'(1) << idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_channel_sched.sv
// ============================================================================
// pulse_channel_sched : shares one toggle/ack pulse channel among N_REQ requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_channel_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 3,
  parameter int GAP_CYC = 2
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  pulse_channel_sched_if.master  bus
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] req_edge;
  logic [N_REQ-1:0] cnt_dec;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] ovf;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_valid;

  state_e           state, state_nxt;
  logic             level, level_nxt;
  logic [ID_W-1:0]  id, id_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             grant_en;

  always_ff @(posedge clk) begin
    if (!reset_n) req_q <= '0;
    else          req_q <= bus.req_pulse;
  end

  assign req_edge = bus.req_pulse & ~req_q;
  assign cnt_dec  = arb_grant & {N_REQ{grant_en}};

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             ovf_r;
    logic             sat_hit;

    // Edge and grant together cancel; an edge on a full counter is lost and flagged.
    assign sat_hit = req_edge[i] && !cnt_dec[i] && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (req_edge[i] && !cnt_dec[i]) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (cnt_dec[i] && !req_edge[i]) begin
        cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n)         ovf_r <= 1'b0;
      else if (sat_hit)     ovf_r <= 1'b1;
      else if (bus.ovf_clr) ovf_r <= 1'b0;
    end

    assign pend[i] = |cnt;
    assign ovf[i]  = ovf_r;
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (pend),
    .update  (grant_en),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      level   <= 1'b0;
      id      <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      id      <= id_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    id_nxt    = id;
    gap_nxt   = gap_cnt;
    grant_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_en  = 1'b1;
          level_nxt = ~level;
          id_nxt    = arb_idx;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.ack_level_sync == level) begin
          if (GAP_CYC > 0) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = ST_IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.sync_level_o = level;
  assign bus.sync_id_o    = id;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.pend_nz      = pend;
  assign bus.ovf_sticky   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_pulse_channel_sched.sv
// Directed bench for pulse_channel_sched (N_REQ=4, CNT_W=3, GAP_CYC=2).
`default_nettype none

module tb_pulse_channel_sched;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  pulse_channel_sched_if #(.N_REQ(4)) bus ();

  pulse_channel_sched #(
    .N_REQ   (4),
    .CNT_W   (3),
    .GAP_CYC (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic       ack;
    logic       clr;
    logic       lvl;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, input logic [3:0] req, input logic ack, input logic clr,
                     input logic lvl, input logic [1:0] id, input logic busy,
                     input logic [3:0] pend, input logic [3:0] ovf);
    vec_t v;
    v.rn = rn; v.req = req; v.ack = ack; v.clr = clr;
    v.lvl = lvl; v.id = id; v.busy = busy; v.pend = pend; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic step(input logic rn, input logic [3:0] req, input logic ack, input logic clr);
    @(negedge clk);
    reset_n            = rn;
    bus.req_pulse      = req;
    bus.ack_level_sync = ack;
    bus.ovf_clr        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic lvl, input logic [1:0] id,
                         input logic busy, input logic [3:0] pend, input logic [3:0] ovf);
    chk({tag, "_level"}, int'(bus.sync_level_o), int'(lvl));
    chk({tag, "_id"},    int'(bus.sync_id_o),    int'(id));
    chk({tag, "_busy"},  int'(bus.busy),         int'(busy));
    chk({tag, "_pend"},  int'(bus.pend_nz),      int'(pend));
    chk({tag, "_ovf"},   int'(bus.ovf_sticky),   int'(ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack_drv;
    logic       prev;
    int         n1;
    int         nother;
    logic       done;

    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.req_pulse = '0;
    bus.ack_level_sync = 1'b0;
    bus.ovf_clr = 1'b0;

    //   rn  req    ack clr  lvl id busy pend   ovf
    add(0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000); // reset
    add(1, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0100, 0, 0,  0, 0, 0, 4'b0100, 4'b0000); // edge on req 2
    add(1, 4'b0100, 0, 0,  1, 2, 1, 4'b0000, 4'b0000); // grant, toggle
    add(1, 4'b0000, 0, 0,  1, 2, 1, 4'b0000, 4'b0000);
    add(1, 4'b0000, 0, 0,  1, 2, 1, 4'b0000, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 2, 1, 4'b0000, 4'b0000); // ack -> GAP
    add(1, 4'b0000, 1, 0,  1, 2, 1, 4'b0000, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 2, 0, 4'b0000, 4'b0000); // -> IDLE
    add(1, 4'b0000, 1, 1,  1, 2, 0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 0, 0,  1, 2, 0, 4'b0000, 4'b0000); // ack moves in IDLE
    add(1, 4'b0000, 1, 0,  1, 2, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000); // reset, pointer back to 0
    add(1, 4'b1011, 0, 0,  0, 0, 0, 4'b1011, 4'b0000); // edges on 0,1,3
    add(1, 4'b1011, 0, 0,  1, 0, 1, 4'b1010, 4'b0000); // grant 0
    add(1, 4'b0000, 0, 0,  1, 0, 1, 4'b1010, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 0, 1, 4'b1010, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 0, 1, 4'b1010, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 0, 0, 4'b1010, 4'b0000);
    add(1, 4'b0001, 1, 0,  0, 1, 1, 4'b1001, 4'b0000); // grant 1, new edge on 0
    add(1, 4'b0001, 1, 0,  0, 1, 1, 4'b1001, 4'b0000);
    add(1, 4'b0000, 0, 0,  0, 1, 1, 4'b1001, 4'b0000);
    add(1, 4'b0000, 0, 0,  0, 1, 1, 4'b1001, 4'b0000);
    add(1, 4'b0000, 0, 0,  0, 1, 0, 4'b1001, 4'b0000);
    add(1, 4'b0000, 0, 0,  1, 3, 1, 4'b0001, 4'b0000); // 3 before the newer 0
    add(1, 4'b0000, 1, 0,  1, 3, 1, 4'b0001, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 3, 1, 4'b0001, 4'b0000);
    add(1, 4'b0000, 1, 0,  1, 3, 0, 4'b0001, 4'b0000);
    add(1, 4'b0000, 1, 0,  0, 0, 1, 4'b0000, 4'b0000); // grant 0
    add(1, 4'b0000, 0, 0,  0, 0, 1, 4'b0000, 4'b0000);
    add(1, 4'b0000, 0, 0,  0, 0, 1, 4'b0000, 4'b0000);
    add(1, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].req, tbl[i].ack, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].id, tbl[i].busy, tbl[i].pend, tbl[i].ovf);
    end

    // Saturation while stalled in WAIT_ACK, then ack stall, then drain.
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0001, 0, 0);
    step(1, 4'b0000, 0, 0);
    chk_all("sat_start", 1, 0, 1, 4'b0000, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      step(1, 4'b0010, 0, 0);
      step(1, 4'b0000, 0, 0);
    end
    chk_all("sat_full", 1, 0, 1, 4'b0010, 4'b0010);
    for (int k = 0; k < 100; k++) begin
      step(1, 4'b0000, 0, 0);
      chk($sformatf("stall%0d_lvl_id", k), int'({bus.sync_level_o, bus.sync_id_o}), 4);
    end
    ack_drv = bus.sync_level_o;
    prev    = bus.sync_level_o;
    n1 = 0; nother = 0; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      step(1, 4'b0000, ack_drv, 0);
      if (bus.sync_level_o != prev) begin
        prev = bus.sync_level_o;
        if (bus.sync_id_o == 2'd1) n1++;
        else                       nother++;
      end
      ack_drv = bus.sync_level_o;
      if (!bus.busy && bus.pend_nz == 4'b0000) done = 1'b1;
    end
    chk("drain_done", int'(done), 1);
    chk("drain_id1_xfers", n1, 7);
    chk("drain_other_xfers", nother, 0);
    chk("ovf_still_set", int'(bus.ovf_sticky), 2);
    step(1, 4'b0000, ack_drv, 1);
    chk("ovf_cleared", int'(bus.ovf_sticky), 0);

    // Edge on a requester in the same cycle it is granted.
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0100, 0, 0);
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 1, 0);
    step(1, 4'b0001, 1, 0);
    chk_all("simul_gap", 1, 2, 1, 4'b0001, 4'b0000);
    step(1, 4'b0000, 1, 0);
    chk_all("simul_idle", 1, 2, 0, 4'b0001, 4'b0000);
    step(1, 4'b0001, 1, 0);
    chk_all("simul_grant", 0, 0, 1, 4'b0001, 4'b0000);
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 0, 0);
    chk_all("simul_second", 1, 0, 1, 4'b0000, 4'b0000);

    // Reset in the middle of a transfer with a count of 3 pending.
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0001, 0, 0);
    step(1, 4'b0000, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b0010, 0, 0);
      step(1, 4'b0000, 0, 0);
    end
    chk_all("mid_pre", 1, 0, 1, 4'b0010, 4'b0000);
    step(0, 4'b0000, 0, 0);
    chk_all("mid_rst", 0, 0, 0, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b0000, 0, 0);
      chk($sformatf("post_rst%0d_lvl_busy", k), int'({bus.sync_level_o, bus.busy}), 0);
    end
    step(1, 4'b0010, 0, 0);
    step(1, 4'b0000, 0, 0);
    chk_all("post_rst_xfer", 1, 1, 1, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
